// File: rtl/alu_sequencer.sv
// alu_sequencer: execute-stage sequencer for RV OP-IMM / OP instructions.
// Accepts an instruction over a valid/ready handshake and latches it. It then
// steps LOADB -> FETCHA -> EXEC, emitting register-file and ALU control
// minterms. Undefined instructions take a one-cycle TRAP instead.
// Ports:
//   clk_i, reset_i (async, active-low)
//   ir_i/ir_valid_i/ir_ready_o : instruction handshake
//   stall_i                    : freeze state and latched IR
//   state_o, done_o, trap_o    : sequencer status
//   alu_imm12_o, ra_ir2_o      : LOADB operand-B select
//   ra_ir1_o                   : FETCHA rs1 read
//   alua_rf_o, ra_ird_o, rf_alu_o, rmask_o : EXEC writeback control
//   cflag_1_o .. lts_en_o      : ALU operation minterms (EXEC only)
module alu_sequencer #(
  parameter int unsigned SHAMT_W   = 5,
  parameter bit          ENABLE_OP = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] ir_i,
  input  logic        ir_valid_i,
  output logic        ir_ready_o,
  input  logic        stall_i,
  output logic [2:0]  state_o,
  output logic        done_o,
  output logic        trap_o,
  output logic        alu_imm12_o,
  output logic        ra_ir2_o,
  output logic        ra_ir1_o,
  output logic        alua_rf_o,
  output logic        ra_ird_o,
  output logic        rf_alu_o,
  output logic [3:0]  rmask_o,
  output logic        cflag_1_o,
  output logic        sum_en_o,
  output logic        and_en_o,
  output logic        xor_en_o,
  output logic        invB_en_o,
  output logic        lsh_en_o,
  output logic        rsh_en_o,
  output logic        ltu_en_o,
  output logic        lts_en_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoadB  = 3'd1,
    StFetchA = 3'd2,
    StExec   = 3'd3,
    StTrap   = 3'd4
  } state_e;

  localparam logic [6:0]  OpcOpImm = 7'b0010011;
  localparam logic [6:0]  OpcOp    = 7'b0110011;
  // imm[11:SHAMT_W] pattern for SRAI: only ir[30] (imm bit 10) set.
  localparam logic [11:0] SraHi    = 12'(12'h400 >> SHAMT_W);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        accept;

  function automatic logic is_defined(logic [31:0] ir);
    logic [11:0] imm_hi;
    logic        ok;
    imm_hi = ir[31:20] >> SHAMT_W;
    ok     = 1'b0;
    if (ir[6:0] == OpcOpImm) begin
      if (ir[14:12] == 3'b001) begin
        ok = (imm_hi == 12'd0);
      end else if (ir[14:12] == 3'b101) begin
        ok = (imm_hi == 12'd0) || (imm_hi == SraHi);
      end else begin
        ok = 1'b1;
      end
    end else if (ENABLE_OP && (ir[6:0] == OpcOp)) begin
      ok = (ir[31:25] == 7'b0000000) ||
           ((ir[31:25] == 7'b0100000) && ((ir[14:12] == 3'b000) || (ir[14:12] == 3'b101)));
    end
    return ok;
  endfunction

  // Ready is forced low during reset so fetch never sees a spurious handshake.
  assign ir_ready_o = reset_i & ~stall_i & ((state_q == StIdle) | (state_q == StExec));
  assign accept     = ir_valid_i & ir_ready_o;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    if (!stall_i) begin
      unique case (state_q)
        StIdle, StExec: begin
          if (accept) begin
            ir_d    = ir_i;
            state_d = is_defined(ir_i) ? StLoadB : StTrap;
          end else begin
            state_d = StIdle;
          end
        end
        StLoadB:  state_d = StFetchA;
        StFetchA: state_d = StExec;
        StTrap:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  logic       is_opimm_q, is_op_q, in_exec;
  logic [8:0] alu_op;

  assign is_opimm_q = (ir_q[6:0] == OpcOpImm);
  assign is_op_q    = ENABLE_OP && (ir_q[6:0] == OpcOp);
  assign in_exec    = (state_q == StExec);

  // {cflag, sum, and, xor, invB, lsh, rsh, ltu, lts}
  always_comb begin
    alu_op = 9'b0;
    unique case (ir_q[14:12])
      3'b000: alu_op = (is_op_q && ir_q[30]) ? 9'b110010000 : 9'b010000000;
      3'b001: alu_op = 9'b000001000;
      3'b010: alu_op = 9'b100010001;
      3'b011: alu_op = 9'b100010010;
      3'b100: alu_op = 9'b000100000;
      // Bit 30 is only ever set on a defined shift-right when it encodes SRA/SRAI.
      3'b101: alu_op = ir_q[30] ? 9'b100000100 : 9'b000000100;
      3'b110: alu_op = 9'b001100000;
      3'b111: alu_op = 9'b001000000;
      default: alu_op = 9'b0;
    endcase
  end

  assign state_o     = state_q;
  assign done_o      = in_exec;
  assign trap_o      = (state_q == StTrap);
  assign alu_imm12_o = (state_q == StLoadB) & is_opimm_q;
  assign ra_ir2_o    = (state_q == StLoadB) & is_op_q;
  assign ra_ir1_o    = (state_q == StFetchA);
  assign alua_rf_o   = in_exec;
  assign ra_ird_o    = in_exec;
  assign rf_alu_o    = in_exec;
  assign rmask_o     = (in_exec && (ir_q[11:7] != 5'd0)) ? 4'b1111 : 4'b0000;
  assign {cflag_1_o, sum_en_o, and_en_o, xor_en_o, invB_en_o,
          lsh_en_o, rsh_en_o, ltu_en_o, lts_en_o} = in_exec ? alu_op : 9'b0;

  // Operand fields of the latched IR belong to the datapath, not the sequencer.
  logic unused_ir;
  assign unused_ir = ^{ir_q[31], ir_q[29:15]};

endmodule
